// File: rtl/am2940_control.sv
// Am2940-style DMA control stage: instruction decode, control/address/word-count registers, transfer countdown.
// Latency: register updates, load pulse, done and read-back one cycle after sampling; addr_enable is combinational; no backpressure.
module am2940_control #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             instr_valid,
    input  logic [2:0]       instr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             aci,
    input  logic             addr_carry,
    output logic             addr_load,
    output logic             addr_enable,
    output logic             addr_up,
    output logic [WIDTH-1:0] addr_data,
    output logic [WIDTH-1:0] data_out,
    output logic             oe,
    output logic [WIDTH-1:0] wc_out,
    output logic [2:0]       cr_out,
    output logic             done
);
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WRCR   = 3'd1;
    localparam logic [2:0] OP_LDADR  = 3'd2;
    localparam logic [2:0] OP_LDWC   = 3'd3;
    localparam logic [2:0] OP_REINIT = 3'd4;
    localparam logic [2:0] OP_ENCNT  = 3'd5;
    localparam logic [2:0] OP_RDCR   = 3'd6;
    localparam logic [2:0] OP_RDWC   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       cr;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] wc_reg;
    logic [WIDTH-1:0] wc;
    logic             is_reinit;
    logic             cfg_ok;
    logic             wc_is_one;
    logic             terminate;

    assign is_reinit   = instr_valid && (instr == OP_REINIT);
    assign cfg_ok      = (state != ST_ACTIVE);
    assign wc_is_one   = (wc == WIDTH'(1));
    // REINIT pre-empts a same-cycle transfer so the reload is not followed by a decrement.
    assign addr_enable = (state == ST_ACTIVE) && aci && !is_reinit;

    assign addr_up = ~cr[2];
    assign cr_out  = cr;
    assign wc_out  = wc;
    assign done    = (state == ST_DONE);

    always_comb begin
        terminate = 1'b0;
        case (cr[1:0])
            2'b00:   terminate = wc_is_one;
            2'b01:   terminate = addr_carry;
            2'b10:   terminate = wc_is_one || addr_carry;
            default: terminate = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= ST_IDLE;
            cr        <= '0;
            addr_reg  <= '0;
            wc_reg    <= '0;
            wc        <= '0;
            addr_load <= 1'b0;
            addr_data <= '0;
            data_out  <= '0;
            oe        <= 1'b0;
        end else begin
            addr_load <= 1'b0;
            oe        <= 1'b0;

            if (addr_enable) begin
                wc <= wc - WIDTH'(1);
                if (terminate)
                    state <= ST_DONE;
            end

            if (instr_valid) begin
                case (instr)
                    OP_WRCR: begin
                        if (cfg_ok)
                            cr <= data_in[2:0];
                    end
                    OP_LDADR: begin
                        if (cfg_ok) begin
                            addr_reg  <= data_in;
                            addr_data <= data_in;
                            addr_load <= 1'b1;
                        end
                    end
                    OP_LDWC: begin
                        if (cfg_ok) begin
                            wc_reg <= data_in;
                            wc     <= data_in;
                        end
                    end
                    OP_REINIT: begin
                        wc        <= wc_reg;
                        addr_data <= addr_reg;
                        addr_load <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    OP_ENCNT: begin
                        // Count-limited modes with nothing to transfer terminate immediately.
                        if (cfg_ok)
                            state <= ((wc == '0) && !cr[0]) ? ST_DONE : ST_ACTIVE;
                    end
                    OP_RDCR: begin
                        data_out <= WIDTH'(cr);
                        oe       <= 1'b1;
                    end
                    OP_RDWC: begin
                        data_out <= wc;
                        oe       <= 1'b1;
                    end
                    OP_NOP:  ;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_am2940_control.sv
// Randomized and directed stimulus for am2940_control against a behavioural reference model.
module tb_am2940_control;
    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       instr_valid = 1'b0;
    logic [2:0] instr = 3'd0;
    logic [3:0] data_in = 4'd0;
    logic       aci = 1'b0;
    logic       addr_carry = 1'b0;
    logic       addr_load, addr_enable, addr_up, oe, done;
    logic [3:0] addr_data, data_out, wc_out;
    logic [2:0] cr_out;

    am2940_control #(.WIDTH(4)) dut (
        .clk(clk), .res(res), .instr_valid(instr_valid), .instr(instr),
        .data_in(data_in), .aci(aci), .addr_carry(addr_carry),
        .addr_load(addr_load), .addr_enable(addr_enable), .addr_up(addr_up),
        .addr_data(addr_data), .data_out(data_out), .oe(oe),
        .wc_out(wc_out), .cr_out(cr_out), .done(done)
    );

    always #5 clk = ~clk;

    localparam int S_IDLE = 0, S_ACTIVE = 1, S_DONE = 2;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_state, m_cr, m_addr, m_wcreg, m_wc, m_adata, m_dout;
    int m_load, m_oe;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_cr = 0; m_addr = 0; m_wcreg = 0; m_wc = 0;
        m_adata = 0; m_dout = 0; m_load = 0; m_oe = 0;
    endtask

    task automatic check_outputs();
        chk("addr_load", int'(addr_load), m_load);
        chk("addr_data", int'(addr_data), m_adata);
        chk("addr_up",   int'(addr_up),   ((m_cr >> 2) & 1) ? 0 : 1);
        chk("data_out",  int'(data_out),  m_dout);
        chk("oe",        int'(oe),        m_oe);
        chk("wc_out",    int'(wc_out),    m_wc);
        chk("cr_out",    int'(cr_out),    m_cr);
        chk("done",      int'(done),      (m_state == S_DONE) ? 1 : 0);
    endtask

    // Apply one sampled cycle to the model, using pre-edge values throughout.
    task automatic model_step(input int v, input int op, input int d, input int c, input int en);
        int mode, old_wc, old_cr, old_state;
        bit term;
        mode = m_cr % 4; old_wc = m_wc; old_cr = m_cr; old_state = m_state;
        m_load = 0; m_oe = 0;
        if (en != 0) begin
            term = (mode == 0 && old_wc == 1) || (mode == 1 && c != 0) ||
                   (mode == 2 && (old_wc == 1 || c != 0));
            m_wc = (old_wc + 15) % 16;
            if (term) m_state = S_DONE;
        end
        if (v != 0) begin
            case (op)
                1: if (old_state != S_ACTIVE) m_cr = d % 8;
                2: if (old_state != S_ACTIVE) begin m_addr = d; m_adata = d; m_load = 1; end
                3: if (old_state != S_ACTIVE) begin m_wcreg = d; m_wc = d; end
                4: begin m_wc = m_wcreg; m_adata = m_addr; m_load = 1; m_state = S_IDLE; end
                5: if (old_state != S_ACTIVE)
                       m_state = (old_wc == 0 && (mode == 0 || mode == 2)) ? S_DONE : S_ACTIVE;
                6: begin m_dout = old_cr; m_oe = 1; end
                7: begin m_dout = old_wc; m_oe = 1; end
                default: ;
            endcase
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input int v, input int op, input int d, input int a, input int c);
        int exp_en;
        instr_valid = (v != 0); instr = 3'(op); data_in = 4'(d);
        aci = (a != 0); addr_carry = (c != 0);
        #1;
        exp_en = (m_state == S_ACTIVE && a != 0 && !(v != 0 && op == 4)) ? 1 : 0;
        chk("addr_enable", int'(addr_enable), exp_en);
        if (addr_load && addr_enable) chk("load_enable_overlap", 1, 0);
        @(posedge clk);
        model_step(v, op, d, c, exp_en);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear with no clock edge.
    task automatic async_reset();
        #2;
        res = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("addr_enable_rst", int'(addr_enable), 0);
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        async_reset();

        // Reset mid-transfer with wc=5, then aci must be ignored
        cycle(1, 3, 5, 0, 0);
        cycle(1, 5, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("pre_reset_wc", int'(wc_out), 4);
        async_reset();
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // Mode 00 count-limited transfer
        cycle(1, 1, 0, 0, 0);
        cycle(1, 2, 4'hA, 0, 0);
        chk("ldadr_pulse_data", int'(addr_data), 10);
        cycle(1, 3, 3, 0, 0);
        cycle(1, 5, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
        chk("mode00_done", int'(done), 1);
        chk("mode00_wc", int'(wc_out), 0);

        // Mode 01 carry-terminated, wc wraps 0 -> F -> E
        cycle(1, 1, 1, 0, 0);
        cycle(1, 3, 0, 0, 0);
        cycle(1, 5, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("mode01_wrap", int'(wc_out), 15);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
        chk("mode01_wc", int'(wc_out), 14);

        // Mode 00 with wc=0 terminates immediately; REINIT clears done
        cycle(1, 1, 0, 0, 0);
        cycle(1, 3, 0, 0, 0);
        cycle(1, 5, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 4, 0, 0, 0);
        idle(1);

        // REINIT wins over aci in ACTIVE; LDWC ignored while ACTIVE
        cycle(1, 1, 3, 0, 0);
        cycle(1, 3, 9, 0, 0);
        cycle(1, 5, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
        cycle(1, 3, 2, 0, 0);
        chk("ldwc_ignored", int'(wc_out), 6);
        cycle(1, 4, 0, 1, 0);
        chk("reinit_wc", int'(wc_out), 9);
        cycle(0, 0, 0, 1, 0);

        // Read-back of cr and wc
        cycle(1, 1, 5, 0, 0);
        cycle(1, 3, 7, 0, 0);
        cycle(1, 6, 0, 0, 0);
        chk("rdcr_data", int'(data_out), 5);
        cycle(1, 7, 0, 0, 0);
        chk("rdwc_data", int'(data_out), 7);
        cycle(0, 0, 0, 0, 0);
        chk("oe_drop", int'(oe), 0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                cycle(($urandom_range(0, 9) < 5) ? 1 : 0, int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7) ? 1 : 0,
                      ($urandom_range(0, 9) < 2) ? 1 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
